pwm_duty_monitor: RTL

Downstream observer for the three PWM channels produced by the RGB mixer. It counts the high cycles of each PWM input over fixed frames of 2^W clock cycles. At each frame boundary it snapshots the three duty counts into a ready/valid output register. This gives firmware and test logic a cycle-exact readback of the encoder-set levels without tapping the mixer internals.

---
 rtl/pwm_duty_monitor.sv | 89 ++++++++
 1 files changed

// File: rtl/pwm_duty_monitor.sv
// Counts high cycles of three PWM channels over 2^W-cycle frames and snapshots
// the per-frame duty counts into a ready/valid output register.
module pwm_duty_monitor #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm0_in,
  input  logic         pwm1_in,
  input  logic         pwm2_in,
  output logic [W:0]   duty0,
  output logic [W:0]   duty1,
  output logic [W:0]   duty2,
  output logic         duty_valid,
  input  logic         duty_ready,
  output logic         frame_end,
  output logic         overrun
);

  localparam int unsigned AW = W + 1;
  localparam logic [W-1:0] FCNT_LAST = '1;

  logic [W-1:0]  fcnt;
  logic [AW-1:0] acc0;
  logic [AW-1:0] acc1;
  logic [AW-1:0] acc2;
  logic [AW-1:0] cap0;
  logic [AW-1:0] cap1;
  logic [AW-1:0] cap2;
  logic          boundary;
  logic          slot_free;
  logic          transfer;

  // The boundary-cycle sample is folded into the capture, never into the next frame.
  always_comb begin
    boundary  = (fcnt == FCNT_LAST);
    slot_free = !duty_valid || duty_ready;
    transfer  = duty_valid && duty_ready;
    cap0      = acc0 + AW'(pwm0_in);
    cap1      = acc1 + AW'(pwm1_in);
    cap2      = acc2 + AW'(pwm2_in);
  end

  // Free-running frame counter and per-channel high-cycle accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt      <= '0;
      acc0      <= '0;
      acc1      <= '0;
      acc2      <= '0;
      frame_end <= 1'b0;
    end else begin
      fcnt      <= fcnt + W'(1);
      frame_end <= boundary;
      if (boundary) begin
        acc0 <= '0;
        acc1 <= '0;
        acc2 <= '0;
      end else begin
        acc0 <= cap0;
        acc1 <= cap1;
        acc2 <= cap2;
      end
    end
  end

  // Snapshot slot: a load at the boundary wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty0      <= '0;
      duty1      <= '0;
      duty2      <= '0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (boundary) begin
      if (slot_free) begin
        duty0      <= cap0;
        duty1      <= cap1;
        duty2      <= cap2;
        duty_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (transfer) begin
      duty_valid <= 1'b0;
    end
  end

endmodule
